ray_gen: RTL and testbench

Camera ray generator that sits in front of the `intersection` datapath and produces its ray input. After a start pulse it streams one primary ray per pixel in raster order (x fastest, then y) over a valid/ready handshake, with origin and direction in the same `[1]` origin / `[0]` direction layout that `intersection` consumes. Each direction is formed incrementally from a latched camera description by vector adds only; the block has no multipliers.

---
 rtl/rt_pkg.sv | 19 +
 rtl/vec3_add.sv | 18 +
 rtl/ray_gen.sv | 134 +++++++++++++
 tb/tb_ray_gen.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_pkg.sv
// Shared ray-tracing types: Q16.16 scalars, 3-vectors and origin/direction rays.
package rt_pkg;

  localparam int FRAC_BITS = 16;

  typedef logic signed [31:0] fix_t;
  typedef fix_t [2:0] vec3_t;
  typedef vec3_t [1:0] ray_t;

  localparam int RAY_ORIG = 1;
  localparam int RAY_DIR  = 0;

  typedef enum logic [1:0] {
    RG_IDLE,
    RG_RUN,
    RG_DONE
  } rg_state_t;

endpackage

// File: rtl/vec3_add.sv
// Three-lane 32-bit two's-complement adder; overflow wraps silently.
module vec3_add
  import rt_pkg::*;
(
  input  vec3_t a,
  input  vec3_t b,
  output vec3_t sum
);

  // Lane-wise wrapping add
  always_comb begin
    sum = '0;
    for (int i = 0; i < 3; i++) begin
      sum[i] = a[i] + b[i];
    end
  end

endmodule

// File: rtl/ray_gen.sv
// Camera ray generator: streams one primary ray per pixel in raster order.
// Directions are built incrementally (cur += du along a row, row += dv per row).
module ray_gen
  import rt_pkg::*;
#(
  parameter int  WIDTH  = 640,
  parameter int  HEIGHT = 480,
  localparam int XW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  input  vec3_t         i_cam_origin,
  input  vec3_t         i_cam_base,
  input  vec3_t         i_cam_du,
  input  vec3_t         i_cam_dv,
  output ray_t          o_ray,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_last,
  output logic          o_valid,
  input  logic          i_ready,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [XW-1:0] X_MAX     = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(HEIGHT - 1);
  localparam logic [XW-1:0] X_ONE     = XW'(1);
  localparam logic [YW-1:0] Y_ONE     = YW'(1);
  localparam logic          X_SINGLE  = (WIDTH == 1);
  localparam logic          ONE_PIXEL = (WIDTH == 1) && (HEIGHT == 1);

  rg_state_t state, state_nxt;

  vec3_t du, dv, row_dir;
  vec3_t dir_du, dir_dv;

  logic          accept;
  logic          start_ok;
  logic          step;
  logic          at_row_end;
  logic          at_last_row;
  logic [XW-1:0] x_inc;
  logic [YW-1:0] y_inc;

  assign accept      = o_valid && i_ready;
  assign start_ok    = (state == RG_IDLE) && i_start;
  assign step        = (state == RG_RUN) && accept && !o_last;
  assign at_row_end  = (o_x == X_MAX);
  assign at_last_row = (o_y == Y_MAX);
  assign x_inc       = o_x + X_ONE;
  assign y_inc       = o_y + Y_ONE;

  // Next direction along the current row, and first direction of the next row
  vec3_add u_add_du (
    .a   (o_ray[RAY_DIR]),
    .b   (du),
    .sum (dir_du)
  );

  vec3_add u_add_dv (
    .a   (row_dir),
    .b   (dv),
    .sum (dir_dv)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= RG_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: DONE always lasts exactly one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      RG_IDLE: if (i_start) state_nxt = RG_RUN;
      RG_RUN:  if (accept && o_last) state_nxt = RG_DONE;
      RG_DONE: state_nxt = RG_IDLE;
      default: state_nxt = RG_IDLE;
    endcase
  end

  // Camera step vectors and row-start direction; only loaded on start or row advance
  always_ff @(posedge clk) begin
    if (start_ok) begin
      du      <= i_cam_du;
      dv      <= i_cam_dv;
      row_dir <= i_cam_base;
    end else if (step && at_row_end) begin
      row_dir <= dir_dv;
    end
  end

  // Registered outputs: status flags, pixel coordinates and the ray itself
  always_ff @(posedge clk) begin
    if (reset) begin
      o_ray   <= '0;
      o_x     <= '0;
      o_y     <= '0;
      o_last  <= 1'b0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_valid <= (state_nxt == RG_RUN);
      o_busy  <= (state_nxt == RG_RUN);
      o_done  <= (state_nxt == RG_DONE);
      if (start_ok) begin
        o_ray[RAY_ORIG] <= i_cam_origin;
        o_ray[RAY_DIR]  <= i_cam_base;
        o_x             <= '0;
        o_y             <= '0;
        o_last          <= ONE_PIXEL;
      end else if (step) begin
        if (at_row_end) begin
          o_x            <= '0;
          o_y            <= y_inc;
          o_ray[RAY_DIR] <= dir_dv;
          o_last         <= X_SINGLE && (y_inc == Y_MAX);
        end else begin
          o_x            <= x_inc;
          o_ray[RAY_DIR] <= dir_du;
          o_last         <= (x_inc == X_MAX) && at_last_row;
        end
      end else if ((state == RG_RUN) && accept) begin
        o_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ray_gen.sv
// Scoreboard bench for ray_gen: three instances (4x3, 2x1, 1x1) share clock,
// reset, camera inputs and ready; expected rays come from a closed-form model.
module tb_ray_gen;
  import rt_pkg::*;

  typedef struct packed {
    ray_t       ray;
    logic [1:0] x;
    logic [1:0] y;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_ready = 1'b0;
  logic [2:0] start = '0;
  vec3_t      cam_org = '0, cam_base = '0, cam_du = '0, cam_dv = '0;

  ray_t       ray_o   [3];
  logic [1:0] x_o     [3];
  logic [1:0] y_o     [3];
  logic       valid_o [3];
  logic       last_o  [3];
  logic       busy_o  [3];
  logic       done_o  [3];
  logic       x_b, y_b, x_c, y_c;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t q [3][$];
  logic pend   [3] = '{1'b0, 1'b0, 1'b0};
  logic hold_v [3] = '{1'b0, 1'b0, 1'b0};
  exp_t snap   [3];

  always #5 clk = ~clk;

  ray_gen #(.WIDTH(4), .HEIGHT(3)) u_a (
    .clk(clk), .reset(reset), .i_start(start[0]),
    .i_cam_origin(cam_org), .i_cam_base(cam_base), .i_cam_du(cam_du), .i_cam_dv(cam_dv),
    .o_ray(ray_o[0]), .o_x(x_o[0]), .o_y(y_o[0]), .o_last(last_o[0]), .o_valid(valid_o[0]),
    .i_ready(i_ready), .o_busy(busy_o[0]), .o_done(done_o[0])
  );

  ray_gen #(.WIDTH(2), .HEIGHT(1)) u_b (
    .clk(clk), .reset(reset), .i_start(start[1]),
    .i_cam_origin(cam_org), .i_cam_base(cam_base), .i_cam_du(cam_du), .i_cam_dv(cam_dv),
    .o_ray(ray_o[1]), .o_x(x_b), .o_y(y_b), .o_last(last_o[1]), .o_valid(valid_o[1]),
    .i_ready(i_ready), .o_busy(busy_o[1]), .o_done(done_o[1])
  );

  ray_gen #(.WIDTH(1), .HEIGHT(1)) u_c (
    .clk(clk), .reset(reset), .i_start(start[2]),
    .i_cam_origin(cam_org), .i_cam_base(cam_base), .i_cam_du(cam_du), .i_cam_dv(cam_dv),
    .o_ray(ray_o[2]), .o_x(x_c), .o_y(y_c), .o_last(last_o[2]), .o_valid(valid_o[2]),
    .i_ready(i_ready), .o_busy(busy_o[2]), .o_done(done_o[2])
  );

  assign x_o[1] = {1'b0, x_b};
  assign y_o[1] = {1'b0, y_b};
  assign x_o[2] = {1'b0, x_c};
  assign y_o[2] = {1'b0, y_c};

  task automatic chk_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t cur(input int k);
    exp_t e;
    e.ray  = ray_o[k];
    e.x    = x_o[k];
    e.y    = y_o[k];
    e.last = last_o[k];
    return e;
  endfunction

  function automatic vec3_t rnd_vec();
    vec3_t v;
    for (int c = 0; c < 3; c++) v[c] = fix_t'($urandom);
    return v;
  endfunction

  // Reference model: direction(x,y) = base + x*du + y*dv, 32-bit wrapping
  task automatic push_frame(input int k, input int w, input int h, input vec3_t org,
                            input vec3_t base, input vec3_t du, input vec3_t dv);
    exp_t e;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        e.ray[RAY_ORIG] = org;
        for (int c = 0; c < 3; c++)
          e.ray[RAY_DIR][c] = base[c] + fix_t'(x) * du[c] + fix_t'(y) * dv[c];
        e.x    = 2'(x);
        e.y    = 2'(y);
        e.last = (x == w - 1) && (y == h - 1);
        q[k].push_back(e);
      end
    end
  endtask

  // Monitor: pops and compares on every accept, checks stall stability and done timing
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        pend[k]   = 1'b0;
        hold_v[k] = 1'b0;
      end else begin
        if (pend[k] || done_o[k]) begin
          chk_int("done_pulse", int'(done_o[k]), int'(pend[k]));
          if (pend[k]) chk_int("valid_in_done", int'(valid_o[k]), 0);
        end
        pend[k] = 1'b0;
        if (hold_v[k])
          chk_vec("stall_hold", 256'({valid_o[k], cur(k)}), 256'({1'b1, snap[k]}));
        hold_v[k] = 1'b0;
        if (valid_o[k] === 1'b1) begin
          if (i_ready) begin
            if (q[k].size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL unexpected_ray: inst %0d got %0h with nothing expected", k, cur(k));
            end else begin
              chk_vec("ray", 256'(cur(k)), 256'(q[k].pop_front()));
            end
            if (last_o[k]) pend[k] = 1'b1;
          end else begin
            hold_v[k] = 1'b1;
            snap[k]   = cur(k);
          end
        end
      end
    end
  end

  task automatic start_frame(input int k, input int w, input int h, input vec3_t org,
                             input vec3_t base, input vec3_t du, input vec3_t dv);
    cam_org  = org;
    cam_base = base;
    cam_du   = du;
    cam_dv   = dv;
    start[k] = 1'b1;
    push_frame(k, w, h, org, base, du, dv);
    @(posedge clk); #1;
    start[k] = 1'b0;
    chk_int("start_valid", int'(valid_o[k]), 1);
    chk_int("start_busy", int'(busy_o[k]), 1);
  endtask

  // mode 0: ready held high; 1: ready pattern 1,0,0,1; 2: random ready
  task automatic run_frame(input int k, input int mode, input int budget, output int cyc);
    int c = 0;
    while (done_o[k] !== 1'b1 && c < budget) begin
      case (mode)
        0:       i_ready = 1'b1;
        1:       i_ready = (c % 4 == 0) || (c % 4 == 3);
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      c++;
    end
    if (c >= budget) begin
      n_cmp++;
      n_fail++;
      $display("FAIL frame_timeout: inst %0d got no done after %0d cycles, required within %0d", k, c, budget);
    end
    cyc = c;
    chk_int("frame_drained", q[k].size(), 0);
    @(posedge clk); #1;
    chk_int("idle_valid", int'(valid_o[k]), 0);
    chk_int("idle_busy", int'(busy_o[k]), 0);
  endtask

  vec3_t base0, du0, dv0, org0;
  int    cyc;

  initial begin
    base0 = '{32'sh10000, 32'sh0, 32'sh0};
    du0   = '{32'sh0, 32'sh0, 32'sh1000};
    dv0   = '{32'sh0, 32'sh1000, 32'sh0};
    org0  = '{32'sh7, 32'sh6, 32'sh5};

    repeat (3) @(posedge clk);
    #1;
    chk_int("rst_valid", int'(valid_o[0]), 0);
    chk_int("rst_busy", int'(busy_o[0]), 0);
    chk_int("rst_done", int'(done_o[0]), 0);
    chk_int("rst_last", int'(last_o[0]), 0);
    chk_int("rst_xy", int'({x_o[0], y_o[0]}), 0);
    chk_vec("rst_ray", 256'(ray_o[0]), 256'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Full frame, back-to-back
    i_ready = 1'b1;
    start_frame(0, 4, 3, org0, base0, du0, dv0);
    run_frame(0, 0, 200, cyc);
    chk_int("b2b_cycles", cyc, 12);

    // Backpressure with ready 1,0,0,1
    start_frame(0, 4, 3, org0, base0, du0, dv0);
    run_frame(0, 1, 400, cyc);

    // Wrap-around of direction x
    start_frame(1, 2, 1, org0, '{32'sh0, 32'sh0, 32'sh7FFFF000}, '{32'sh0, 32'sh0, 32'sh1000}, '0);
    run_frame(1, 0, 50, cyc);
    chk_int("wrap_cycles", cyc, 2);

    // Start while busy: second start with a different camera is ignored
    start_frame(0, 4, 3, org0, base0, du0, dv0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    cam_org  = rnd_vec();
    cam_base = rnd_vec();
    cam_du   = rnd_vec();
    cam_dv   = rnd_vec();
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    run_frame(0, 0, 200, cyc);
    chk_int("busy_start_cycles", cyc, 7);

    // Reset after 5 accepted rays
    start_frame(0, 4, 3, org0, base0, du0, dv0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_int("abort_valid", int'(valid_o[0]), 0);
    chk_int("abort_busy", int'(busy_o[0]), 0);
    chk_int("abort_done", int'(done_o[0]), 0);
    chk_vec("abort_ray", 256'(ray_o[0]), 256'(0));
    q[0].delete();
    @(posedge clk); #1;
    chk_int("abort_no_done", int'(done_o[0]), 0);
    start_frame(0, 4, 3, rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
    run_frame(0, 2, 400, cyc);

    // 1x1 frame
    i_ready = 1'b0;
    start_frame(2, 1, 1, '{32'sh3, 32'sh2, 32'sh1}, rnd_vec(), rnd_vec(), rnd_vec());
    chk_int("one_px_last", int'(last_o[2]), 1);
    run_frame(2, 0, 50, cyc);
    chk_int("one_px_cycles", cyc, 1);

    // Random cameras with random backpressure
    repeat (3) begin
      start_frame(0, 4, 3, rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
      run_frame(0, 2, 400, cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
